// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port RAM between the
// instruction-fetch port (IF, read only) and the load/store port (LS).
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT | IDLE).
//
// Handshake: a requester raises *_req with its fields stable and holds them
// until *_gnt pulses; gnt coincides with the single mem_en cycle. A read
// completes with a one-cycle *_rvalid pulse; *_rdata holds until the next
// read for that requester completes. Requests are only sampled in IDLE.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests (default build is fixed priority, LS over IF).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [1:0]        ls_size,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       owner_ls;   // 1 = LS owns the current transaction, 0 = IF
  logic       pick_ls;    // arbitration winner for this IDLE cycle

`ifdef MEM_ARB_RR_EN
  logic       last_ls;    // requester granted most recently

  // Round-robin: on a collision the requester not granted last wins.
  always_comb begin
    pick_ls = ls_req;
    if (ls_req && if_req) pick_ls = !last_ls;
  end
`else
  // Fixed priority: LS wins whenever it requests.
  always_comb begin
    pick_ls = ls_req;
  end
`endif

  // Arbiter FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner_ls  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls   <= 1'b0;
`endif
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_en    <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state    <= ISSUE;
            owner_ls <= pick_ls;
            mem_en   <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_ls  <= pick_ls;
`endif
            if (pick_ls) begin
              ls_gnt    <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_size  <= ls_size;
            end else begin
              // IF is always a word read.
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_size  <= 2'b10;
            end
          end
        end

        ISSUE: begin
          // A write is complete once strobed; a read waits out the RAM latency.
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT;
          end
        end

        WAIT: begin
          if (lat_cnt == 3'd1) begin
            state   <= IDLE;
            lat_cnt <= '0;
            if (owner_ls) begin
              ls_rdata  <= mem_rdata;
              ls_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
